palette_encoder: RTL

Reverse of the 16-entry sprite palette lookup: takes a 12-bit RGB pixel and returns the 4-bit index of the nearest palette colour. The palette is a writable 16×12-bit register file. The block sits between the frame/sprite capture path and index-based sprite ROM generation. It runs a sequential 16-step squared-distance search with valid/ready handshakes on both sides.

---
 rtl/palette_encoder_if.sv | 25 ++
 rtl/palette_encoder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/palette_encoder_if.sv
// Handshake and palette-write bundle for palette_encoder.
// master = pixel/palette source side, slave = the encoder.
interface palette_encoder_if;
  logic        pal_we;
  logic [3:0]  pal_waddr;
  logic [11:0] pal_wdata;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_rgb;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_index;
  logic [9:0]  out_dist;
  logic        out_exact;

  modport master (
    output pal_we, pal_waddr, pal_wdata, in_valid, in_rgb, out_ready,
    input  in_ready, out_valid, out_index, out_dist, out_exact
  );

  modport slave (
    input  pal_we, pal_waddr, pal_wdata, in_valid, in_rgb, out_ready,
    output in_ready, out_valid, out_index, out_dist, out_exact
  );
endinterface

// File: rtl/palette_encoder.sv
// Nearest-colour search over a writable 16x12-bit palette (sequential, one entry per clock).
// Optional: define PALETTE_ENCODER_EARLY_EXIT_EN to finish the search on the first exact match.
module palette_encoder #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clk,
  input  logic               reset_n,
  palette_encoder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t             state_reg, state_next;
  logic [11:0]        pal_reg [ENTRIES];
  logic [11:0]        pix_reg;
  logic [IDX_W-1:0]   cnt_reg;
  logic [9:0]         best_dist_reg;
  logic [IDX_W-1:0]   best_idx_reg;
  logic [IDX_W-1:0]   out_index_reg;
  logic [9:0]         out_dist_reg;
  logic               out_exact_reg;

  logic [11:0]        cur_entry;
  logic [9:0]         cur_dist;
  logic               cur_better;
  logic [9:0]         cand_dist;
  logic [IDX_W-1:0]   cand_idx;
  logic               accept;
  logic               load_result;

  function automatic logic [7:0] sq_diff(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] d;
    d = (a > b) ? (a - b) : (b - a);
    return {4'd0, d} * {4'd0, d};
  endfunction

  // Palette entries are individual registers so reset can clear all of them.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_pal
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          pal_reg[gi] <= 12'h000;
        else if (bus.pal_we && (bus.pal_waddr == IDX_W'(gi)))
          pal_reg[gi] <= bus.pal_wdata;
      end
    end
  endgenerate

  // The entry under evaluation is read live, before any write landing on this edge.
  assign cur_entry  = pal_reg[cnt_reg];
  assign cur_dist   = {2'd0, sq_diff(pix_reg[11:8], cur_entry[11:8])}
                    + {2'd0, sq_diff(pix_reg[7:4],  cur_entry[7:4])}
                    + {2'd0, sq_diff(pix_reg[3:0],  cur_entry[3:0])};
  assign cur_better = cur_dist < best_dist_reg;
  assign cand_dist  = cur_better ? cur_dist : best_dist_reg;
  assign cand_idx   = cur_better ? cnt_reg  : best_idx_reg;

  assign accept     = (state_reg == IDLE) && bus.in_valid;

  always_comb begin
    state_next  = state_reg;
    load_result = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) state_next = SEARCH;
      end
      SEARCH: begin
        if (cnt_reg == IDX_W'(ENTRIES - 1)) begin
          state_next  = DONE;
          load_result = 1'b1;
        end
`ifdef PALETTE_ENCODER_EARLY_EXIT_EN
        else if (cur_dist == 10'd0) begin
          state_next  = DONE;
          load_result = 1'b1;
        end
`endif
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      pix_reg       <= 12'h000;
      cnt_reg       <= '0;
      best_dist_reg <= 10'd1023;
      best_idx_reg  <= '0;
      out_index_reg <= '0;
      out_dist_reg  <= 10'd0;
      out_exact_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        pix_reg       <= bus.in_rgb;
        cnt_reg       <= '0;
        best_dist_reg <= 10'd1023;
        best_idx_reg  <= '0;
      end else if (state_reg == SEARCH) begin
        cnt_reg       <= cnt_reg + 1'b1;
        best_dist_reg <= cand_dist;
        best_idx_reg  <= cand_idx;
      end
      // Result registers move only on the SEARCH->DONE edge.
      if (load_result) begin
        out_index_reg <= cand_idx;
        out_dist_reg  <= cand_dist;
        out_exact_reg <= (cand_dist == 10'd0);
      end
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_index = out_index_reg;
  assign bus.out_dist  = out_dist_reg;
  assign bus.out_exact = out_exact_reg;

endmodule
